keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner for ROWS x COLS keypads. Successor to the fixed 4x3 scanner.
- Drives one-hot row strobes at a programmable dwell rate and samples the active-high column inputs.
- Debounces over whole scan frames and reports press/release events plus a multi-key flag.
- Feeds game/menu control logic with clean, single-cycle key events.

Parameters:
- ROWS, 4, number of row strobes (>=2).
- COLS, 3, number of column inputs (>=2).
- SCAN_DIV, 1000, clock cycles each row is driven before sampling (>=2).
- DEBOUNCE, 4, consecutive identical frames required to commit a change (>=1).
- CODE_W, 4, key code width; ROWS*COLS <= 2^CODE_W - 1 is required.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- key_col  input  COLS  column sense, active-high; bit COLS-1 is column index 0.
- key_row  output  ROWS  one-hot row strobe; bit ROWS-1 is row index 0.
- key_code  output  CODE_W  committed key code; all-ones = no key.
- key_valid  output  1  level, high while a committed key is held.
- key_press  output  1  one-cycle pulse on commit of a new key.
- key_release  output  1  one-cycle pulse on commit of release or key change.
- multi_key  output  1  level, high when the last frame saw more than one key.

Behaviour:
- Reset (async, rst=1) sets all outputs and state:
  - key_row = bit ROWS-1 set, row_idx=0, div=0;
  - key_code = all-ones, key_valid=0, key_press=0, key_release=0, multi_key=0;
  - accumulators cleared; stable_cnt=0; last_cand=none.
- Divider: div increments every clock. When div==SCAN_DIV-1:
  - key_col is sampled and div returns to 0;
  - row_idx advances, wrapping from ROWS-1 to 0;
  - key_row is registered as the one-hot of the new row_idx.
- Row dwell is SCAN_DIV cycles. Frame length F = ROWS*SCAN_DIV cycles.
- Sampling and key index:
  - Each sampled set bit is a key with code = row_idx*COLS + col_idx.
  - Per frame, accumulate the count of set bits (saturating at 2) and the code of the first key found.
- End of frame (the sample taken with row_idx==ROWS-1), evaluated on that edge using accumulator plus current sample:
  - candidate = key code if count==1; none if count==0 or count>=2.
  - multi_key <= (count>=2); held until the next frame end.
  - If candidate==last_cand, stable_cnt increments, saturating at DEBOUNCE; otherwise stable_cnt=1 and last_cand=candidate.
  - Accumulators clear for the next frame.
- Commit, evaluated on the same edge with the updated stable_cnt: if stable_cnt==DEBOUNCE and candidate differs from key_code, then:
  - none -> key K: key_code<=K, key_valid<=1, key_press pulses.
  - key -> none: key_code<=all-ones, key_valid<=0, key_release pulses.
  - key A -> key B: key_code<=B, key_valid stays 1, key_release and key_press pulse in the same cycle.
- Pulses are high exactly one cycle, the cycle after the frame-end edge. No event fires while the committed state is unchanged.
- Latency: with a stable key from frame start, commit occurs at the end of the DEBOUNCE-th frame, i.e. DEBOUNCE*F cycles.
- Any bounce that changes the candidate restarts the count. Multi-key frames count as none, so a chord held long enough releases any committed key.
- Reset mid-operation aborts the scan and any pending debounce immediately. No release pulse is generated.
- Column inputs are assumed already synchronised; no internal sync stage.

Test Plan:
- Config for all scenarios: ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE=2, so F=16.
- Idle after reset: key_row cycles 1000,0100,0010,0001 with 4 cycles each; key_code=4'hF, key_valid=0, and no pulses over 10 frames.
- Press row1/col1 (key_col=3'b010 whenever key_row=0100) from frame start for 4 frames: key_press pulses once at end of frame 2; key_code=4'd4; key_valid=1. Removing the key for 2 frames gives a key_release pulse and key_code=4'hF.
- Bounce: press present on alternating frames for 8 frames: no pulses, key_code stays 4'hF.
- Chord: key_col=3'b110 on row0 for 3 frames: multi_key=1 from the first frame end, no key_press, key_code=4'hF. Clearing the chord drops multi_key at the next frame end.
- Slide: key code 0 committed, then row3/col2 (code 11) only, for 2 frames: key_release and key_press pulse in the same cycle, key_code=4'd11, key_valid stays 1.
- Async reset asserted mid-frame while key code 4 is committed: outputs return to reset values immediately without a clock edge and with no release pulse. After reset drops, holding the key again gives key_press 32 cycles later.

Source files
------------

// File: rtl/keypad_scanner.sv
// Parametrised ROWS x COLS matrix-keypad scanner with frame-level debounce.
// Emits single-cycle press/release events and a multi-key flag.
module keypad_scanner #(
   parameter int ROWS     = 4,
   parameter int COLS     = 3,
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4,
   parameter int CODE_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [COLS-1:0]   key_col,
   output logic [ROWS-1:0]   key_row,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_press,
   output logic              key_release,
   output logic              multi_key
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RW = $clog2(ROWS);
   localparam int SW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0]     DIV_MAX    = DW'(SCAN_DIV - 1);
   localparam logic [RW-1:0]     ROW_LAST   = RW'(ROWS - 1);
   localparam logic [SW-1:0]     STABLE_MAX = SW'(DEBOUNCE);
   localparam logic [CODE_W-1:0] NONE       = '1;
   localparam logic [ROWS-1:0]   ROW0_OH    = {1'b1, {(ROWS-1){1'b0}}};

   logic [DW-1:0]     div;
   logic [RW-1:0]     row_idx;
   logic [1:0]        acc_cnt;
   logic [CODE_W-1:0] acc_code;
   logic [SW-1:0]     stable_cnt;
   logic [CODE_W-1:0] last_cand;

   logic              tick;
   logic              frame_end;
   logic [RW-1:0]     nxt_idx;
   logic [ROWS-1:0]   row_oh;
   logic [1:0]        row_cnt;
   logic [CODE_W-1:0] row_code;
   logic [2:0]        sum;
   logic [1:0]        tot;
   logic [CODE_W-1:0] frm_code;
   logic [CODE_W-1:0] cand;
   logic [SW-1:0]     nxt_stable;
   logic              commit;

   always_comb begin
      tick      = (div == DIV_MAX);
      frame_end = tick && (row_idx == ROW_LAST);
      nxt_idx   = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
      row_oh    = '0;
      for (int r = 0; r < ROWS; r++) begin
         row_oh[ROWS-1-r] = (nxt_idx == RW'(r));
      end
   end

   // Count set columns (saturating at 2); lowest column index wins the code.
   always_comb begin
      row_cnt  = '0;
      row_code = NONE;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (key_col[COLS-1-c]) begin
            row_code = CODE_W'(int'(row_idx) * COLS + c);
            if (row_cnt != 2'd2) row_cnt = row_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      sum      = {1'b0, acc_cnt} + {1'b0, row_cnt};
      tot      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      frm_code = (acc_cnt == 2'd0) ? row_code : acc_code;
      cand     = (tot == 2'd1) ? frm_code : NONE;
      if (cand != last_cand) begin
         nxt_stable = SW'(1);
      end else if (stable_cnt == STABLE_MAX) begin
         nxt_stable = stable_cnt;
      end else begin
         nxt_stable = stable_cnt + 1'b1;
      end
      commit = (nxt_stable == STABLE_MAX) && (cand != key_code);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div         <= '0;
         row_idx     <= '0;
         key_row     <= ROW0_OH;
         acc_cnt     <= '0;
         acc_code    <= NONE;
         stable_cnt  <= '0;
         last_cand   <= NONE;
         key_code    <= NONE;
         key_valid   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         multi_key   <= 1'b0;
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         if (tick) begin
            div     <= '0;
            row_idx <= nxt_idx;
            key_row <= row_oh;
            if (frame_end) begin
               acc_cnt    <= '0;
               acc_code   <= NONE;
               multi_key  <= (tot == 2'd2);
               stable_cnt <= nxt_stable;
               last_cand  <= cand;
               if (commit) begin
                  key_code    <= cand;
                  key_valid   <= (cand != NONE);
                  key_press   <= (cand != NONE);
                  key_release <= (key_code != NONE);
               end
            end else begin
               acc_cnt  <= tot;
               acc_code <= frm_code;
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner (4x3, SCAN_DIV=4, DEBOUNCE=2) with a
// frame-level keypad model driving key_col from a set of held keys.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] key_col;
   logic [3:0] key_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_press;
   logic       key_release;
   logic       multi_key;

   logic [11:0] keys = '0;
   int errors = 0;
   int checks = 0;

   int m_code   = 15;
   bit m_valid  = 0;
   bit m_multi  = 0;
   int m_last   = 15;
   int m_stable = 0;

   keypad_scanner #(
      .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(2), .CODE_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_col(key_col),
      .key_row(key_row),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_press(key_press),
      .key_release(key_release),
      .multi_key(multi_key)
   );

   always #5 clk = ~clk;

   // Physical keypad: a held key connects its row strobe to its column.
   always_comb begin
      key_col = '0;
      for (int r = 0; r < 4; r++) begin
         if (key_row[3-r]) begin
            for (int c = 0; c < 3; c++) key_col[2-c] = keys[r*3+c];
         end
      end
   end

   task automatic model_reset();
      m_code = 15; m_valid = 0; m_multi = 0; m_last = 15; m_stable = 0;
   endtask

   // Hold key set k for one whole frame; starts just after a frame boundary.
   task automatic run_frame(input logic [11:0] k);
      int n, first, cand, pc;
      bit ep, er, pv, pm;
      keys = k;
      n = $countones(k);
      first = 15;
      for (int i = 11; i >= 0; i--) if (k[i]) first = i;
      cand = (n == 1) ? first : 15;
      pc = m_code; pv = m_valid; pm = m_multi;
      ep = 0; er = 0;
      m_multi = (n >= 2);
      if (cand == m_last) m_stable = (m_stable >= 2) ? 2 : m_stable + 1;
      else begin m_stable = 1; m_last = cand; end
      if (m_stable == 2 && cand != m_code) begin
         er = (m_code != 15);
         ep = (cand != 15);
         m_code = cand;
         m_valid = (cand != 15);
      end
      for (int j = 1; j <= 16; j++) begin
         @(posedge clk); #1;
         checks++;
         if (key_row !== (4'b1000 >> ((j / 4) % 4))) begin
            errors++;
            $display("FAIL row_strobe cyc=%0d got=%b exp=%b", j, key_row, 4'b1000 >> ((j / 4) % 4));
         end
         if (j < 16) begin
            checks++;
            if (key_press !== 1'b0 || key_release !== 1'b0 || key_code !== 4'(pc)
                || key_valid !== pv || multi_key !== pm) begin
               errors++;
               $display("FAIL mid_frame cyc=%0d got p=%b r=%b code=%0d v=%b m=%b exp p=0 r=0 code=%0d v=%b m=%b",
                        j, key_press, key_release, key_code, key_valid, multi_key, pc, pv, pm);
            end
         end else begin
            checks++;
            if (key_press !== ep || key_release !== er) begin
               errors++;
               $display("FAIL frame_end_pulse got p=%b r=%b exp p=%b r=%b", key_press, key_release, ep, er);
            end
            checks++;
            if (key_code !== 4'(m_code) || key_valid !== m_valid || multi_key !== m_multi) begin
               errors++;
               $display("FAIL frame_end_state got code=%0d v=%b m=%b exp code=%0d v=%b m=%b",
                        key_code, key_valid, multi_key, m_code, m_valid, m_multi);
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (key_row !== 4'b1000 || key_code !== 4'hF || key_valid !== 1'b0
          || key_press !== 1'b0 || key_release !== 1'b0 || multi_key !== 1'b0) begin
         errors++;
         $display("FAIL %s got row=%b code=%h v=%b p=%b r=%b m=%b exp row=1000 code=f v=0 p=0 r=0 m=0",
                  tag, key_row, key_code, key_valid, key_press, key_release, multi_key);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      keys = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_idle();
      repeat (10) run_frame(12'h000);
   endtask

   task automatic test_press_release();
      repeat (4) run_frame(12'h010);
      checks++;
      if (key_code !== 4'd4 || key_valid !== 1'b1) begin
         errors++;
         $display("FAIL press_held got code=%0d v=%b exp code=4 v=1", key_code, key_valid);
      end
      repeat (2) run_frame(12'h000);
   endtask

   task automatic test_bounce();
      for (int f = 0; f < 8; f++) run_frame((f % 2 == 0) ? 12'h010 : 12'h000);
      checks++;
      if (key_code !== 4'hF) begin
         errors++;
         $display("FAIL bounce_code got=%h exp=f", key_code);
      end
   endtask

   task automatic test_chord();
      repeat (3) run_frame(12'h003);
      run_frame(12'h000);
   endtask

   task automatic test_slide();
      repeat (2) run_frame(12'h001);
      repeat (2) run_frame(12'h800);
      checks++;
      if (key_code !== 4'd11 || key_valid !== 1'b1) begin
         errors++;
         $display("FAIL slide_state got code=%0d v=%b exp code=11 v=1", key_code, key_valid);
      end
      repeat (2) run_frame(12'h000);
   endtask

   task automatic test_async_reset();
      repeat (2) run_frame(12'h010);
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset_immediate");
      keys = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("async_reset_held");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) run_frame(12'h010);
      repeat (2) run_frame(12'h000);
   endtask

   task automatic test_random();
      logic [11:0] one;
      logic [11:0] k;
      int kind, hold, a, b;
      one = 12'd1;
      for (int f = 0; f < 40; f += hold) begin
         kind = $urandom_range(0, 3);
         hold = $urandom_range(1, 3);
         a = $urandom_range(0, 11);
         b = (a + $urandom_range(1, 11)) % 12;
         case (kind)
            0:       k = '0;
            3:       k = (one << a) | (one << b);
            default: k = one << a;
         endcase
         repeat (hold) run_frame(k);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_press_release();
      test_bounce();
      test_chord();
      test_slide();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
